mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Owns the shared 16x8 instruction/data memory and arbitrates single-cycle read/write accesses between two requesters.
- Port A is the CPU fetch/execute path. Port B is the program loader/debug path.
- Round-robin fairness on conflict.
- Lock mechanism so the CPU can perform atomic read-modify-write (memory double, memory complement) without loader interference.
- Lock timeout protects against a hung owner.

Parameters:
- ADDR_W, 4, memory address width (depth = 2**ADDR_W = 16).
- DATA_W, 8, memory word width.
- LOCK_MAX, 4, idle cycles a lock owner may hold the lock without an accepted transaction before forced release.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- a_req  in  1  port A access request.
- a_we  in  1  port A write enable (1 = write, 0 = read).
- a_lock  in  1  port A requests lock retention after this access.
- a_addr  in  ADDR_W  port A address.
- a_wdata  in  DATA_W  port A write data.
- a_gnt  out  1  port A grant (combinational).
- a_rvalid  out  1  port A read data valid.
- a_rdata  out  DATA_W  port A read data.
- b_req, b_we, b_lock, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as port A, for port B.
- lock_err  out  1  one-cycle pulse on lock timeout.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is synchronous and active-low: sampled only at the rising edge of clk.
- Reset values:
  - a_gnt = b_gnt = 0 (forced combinationally while rst_n = 0).
  - a_rvalid = b_rvalid = 0; a_rdata = b_rdata = 0; lock_err = 0.
  - state = IDLE; last_winner = B, so A wins the first conflict; lock_cnt = 0.
  - Memory contents are not cleared by reset.
- Handshake:
  - A transaction is accepted at the posedge where req & gnt = 1.
  - At most one grant per cycle.
  - Requesters hold addr/we/wdata/lock stable while req = 1 and gnt = 0.
- Latency:
  - Write is committed at the accepting edge.
  - Read data is registered: x_rvalid = 1 and x_rdata valid for exactly the cycle after acceptance.
  - A read in the cycle after a write to the same address returns the new data.
  - x_rdata holds its last value when x_rvalid = 0.
- FSM states: IDLE, LOCK_A, LOCK_B.
- IDLE:
  - Only one requester → grant it.
  - Both requesting → grant the requester that is not last_winner.
  - On acceptance: last_winner ← winner.
  - Accepted with lock = 1 → go to LOCK_<winner> and clear lock_cnt.
- LOCK_A / LOCK_B:
  - Only the owner can be granted; the other port's gnt = 0 regardless of its req.
  - Owner access accepted with lock = 1 → stay in the lock state, lock_cnt ← 0.
  - Owner access accepted with lock = 0 → return to IDLE. The other port may be granted in the very next cycle.
  - No owner acceptance → lock_cnt increments.
  - lock_cnt reaching LOCK_MAX → IDLE, lock_err = 1 for one cycle, lock_cnt ← 0.
- lock_cnt is saturation-safe: width = clog2(LOCK_MAX+1).
- Simultaneous events:
  - Timeout and owner acceptance in the same cycle → the acceptance wins; no lock_err.
  - rst_n low in any state → same-edge return to the reset values above, including LOCK_* states and pending rvalid. An in-flight read is dropped (rvalid not asserted).
- Address wrap: addresses are taken modulo 2**ADDR_W; no out-of-range case exists.

Decomposition:
- Package mem_arb_pkg contains:
  - ADDR_W and DATA_W defaults.
  - State enum: IDLE, LOCK_A, LOCK_B.
  - Requester id enum: REQ_A, REQ_B.
- Sub-module mem_16x8:
  - Synchronous write, registered read, single port.
  - Muxed inputs from the arbiter.
  - No reset on the array; reset applies to its read register only.

Test Plan:
1. Reset behaviour: hold rst_n = 0 for 2 cycles with a_req = b_req = 1 → a_gnt = b_gnt = 0, rvalid = 0, rdata = 0, lock_err = 0 throughout.
2. Write then read: B writes addr 3 = 0x18, then A reads addr 3 → a_rvalid = 1 one cycle after A's acceptance, a_rdata = 0x18; b_rvalid stays 0.
3. Round-robin: A and B both request reads continuously (A addr 0, B addr 1) → grants alternate A, B, A, B starting with A. Each rvalid follows its grant by one cycle.
4. Lock RMW: A reads addr 5 with lock = 1 while B holds b_req = 1 → b_gnt = 0 until A writes addr 5 = ~old with lock = 0. B is granted the following cycle; a later read returns the complemented value.
5. Lock timeout: A accepted with lock = 1, then A drops req and B requests → lock_err pulses exactly once, LOCK_MAX = 4 cycles after A's acceptance. b_gnt = 1 on the next cycle.
6. Reset mid-lock: enter LOCK_B, assert rst_n = 0 for one cycle, then both request → state IDLE and A granted first (last_winner reset to B); no lock_err.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
//   ADDR_W_DEF / DATA_W_DEF / LOCK_MAX_DEF : default geometry and lock timeout
//   arb_state_e : arbiter FSM state
//   req_id_e    : requester identity (used for round-robin history)
package mem_arb_pkg;

  localparam int ADDR_W_DEF   = 4;
  localparam int DATA_W_DEF   = 8;
  localparam int LOCK_MAX_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage

// File: rtl/mem_16x8.sv
// Single-port memory: synchronous write, registered read.
// The array is never reset; only the read register is.
//   clk, rst_n : clock, synchronous active-low reset (read register only)
//   en, we     : access strobe and write enable
//   addr, wdata: access address and write data
//   rdata      : registered read data, holds between reads
module mem_16x8
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en && we) mem_q[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)         rdata_q <= '0;
    else if (en && !we) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the shared instruction/data memory.
// Port A is the CPU path, port B the loader/debug path. Round-robin on
// conflict; a port may hold a lock across accesses for atomic RMW, and an
// idle lock owner is evicted after LOCK_MAX cycles with a lock_err pulse.
//   clk, rst_n               : clock, synchronous active-low reset
//   x_req/we/lock/addr/wdata : requester x access (x = a, b)
//   x_gnt                    : combinational grant
//   x_rvalid, x_rdata        : read data, valid the cycle after acceptance
//   lock_err                 : one-cycle pulse on lock timeout
//
// state  | meaning
// IDLE   | no lock held, round-robin between requesters
// LOCK_A | port A owns the memory, port B is blocked
// LOCK_B | port B owns the memory, port A is blocked
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic              a_lock,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              lock_err
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_e        state_q, state_d;
  req_id_e           last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              lock_err_q, lock_err_d;
  logic              a_rvalid_q, b_rvalid_q;
  logic [DATA_W-1:0] a_hold_q, b_hold_q;

  logic              mem_en, sel_b, win_lock;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  req_id_e           win_id;

  // Grants are gated by rst_n so nothing is accepted on a reset edge.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (a_req && b_req) begin
            a_gnt = (last_q == REQ_B);
            b_gnt = (last_q == REQ_A);
          end else begin
            a_gnt = a_req;
            b_gnt = b_req;
          end
        end
        LOCK_A:  a_gnt = a_req;
        LOCK_B:  b_gnt = b_req;
        default: ;
      endcase
    end
  end

  assign mem_en    = a_gnt | b_gnt;
  assign sel_b     = b_gnt;
  assign mem_we    = sel_b ? b_we    : a_we;
  assign mem_addr  = sel_b ? b_addr  : a_addr;
  assign mem_wdata = sel_b ? b_wdata : a_wdata;
  assign win_lock  = sel_b ? b_lock  : a_lock;
  assign win_id    = sel_b ? REQ_B   : REQ_A;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    lock_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_en) begin
          last_d = win_id;
          if (win_lock) begin
            state_d = sel_b ? LOCK_B : LOCK_A;
            cnt_d   = '0;
          end
        end
      end
      LOCK_A, LOCK_B: begin
        // Only the owner can be granted here, so mem_en means owner access.
        // Checking it first lets an access on the timeout cycle win.
        if (mem_en) begin
          last_d = win_id;
          cnt_d  = '0;
          if (!win_lock) state_d = IDLE;
        end else if (cnt_q == CNT_W'(LOCK_MAX - 1)) begin
          state_d    = IDLE;
          cnt_d      = '0;
          lock_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= REQ_B;
      cnt_q      <= '0;
      lock_err_q <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_hold_q   <= '0;
      b_hold_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      lock_err_q <= lock_err_d;
      a_rvalid_q <= a_gnt & ~a_we;
      b_rvalid_q <= b_gnt & ~b_we;
      if (a_rvalid_q) a_hold_q <= mem_rdata;
      if (b_rvalid_q) b_hold_q <= mem_rdata;
    end
  end

  mem_16x8 #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (mem_en),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

  // The read register is shared; each port keeps its own copy of the last
  // word it was given so its rdata holds while the other port reads.
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rvalid_q ? mem_rdata : a_hold_q;
  assign b_rdata  = b_rvalid_q ? mem_rdata : b_hold_q;
  assign lock_err = lock_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_req, a_we, a_lock, b_req, b_we, b_lock;
  logic [3:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid, lock_err;
  logic [7:0] a_rdata, b_rdata;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(4), .DATA_W(8), .LOCK_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .lock_err(lock_err)
  );

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic drv_a(input logic req, input logic we, input logic lock,
                       input logic [3:0] addr, input logic [7:0] wdata);
    a_req = req; a_we = we; a_lock = lock; a_addr = addr; a_wdata = wdata;
  endtask

  task automatic drv_b(input logic req, input logic we, input logic lock,
                       input logic [3:0] addr, input logic [7:0] wdata);
    b_req = req; b_we = we; b_lock = lock; b_addr = addr; b_wdata = wdata;
  endtask

  // Inputs change at the falling edge; checks run 1ns later, well away
  // from the rising edge, so registered outputs reflect the previous edge.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drv_a(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    drv_b(1'b1, 1'b0, 1'b0, 4'd1, 8'h00);

    // Reset: both requesting, nothing granted, registered outputs cleared.
    for (int i = 0; i < 2; i++) begin
      next_cycle(); settle();
      check("rst a_gnt", 8'(a_gnt), 8'h0);
      check("rst b_gnt", 8'(b_gnt), 8'h0);
      check("rst a_rvalid", 8'(a_rvalid), 8'h0);
      check("rst b_rvalid", 8'(b_rvalid), 8'h0);
      check("rst a_rdata", a_rdata, 8'h00);
      check("rst b_rdata", b_rdata, 8'h00);
      check("rst lock_err", 8'(lock_err), 8'h0);
    end

    // Round-robin from reset: A first, then alternating.
    next_cycle();
    rst_n = 1'b1;
    drv_a(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    drv_b(1'b1, 1'b0, 1'b0, 4'd1, 8'h00);
    for (int k = 0; k < 6; k++) begin
      settle();
      check("rr a_gnt", 8'(a_gnt), 8'((k % 2) == 0));
      check("rr b_gnt", 8'(b_gnt), 8'((k % 2) == 1));
      if (k > 0) begin
        check("rr a_rvalid", 8'(a_rvalid), 8'(((k - 1) % 2) == 0));
        check("rr b_rvalid", 8'(b_rvalid), 8'(((k - 1) % 2) == 1));
      end
      next_cycle();
    end
    drv_a(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    drv_b(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    settle();
    check("rr last b_rvalid", 8'(b_rvalid), 8'h1);
    check("rr last a_rvalid", 8'(a_rvalid), 8'h0);

    // B writes addr 3, A reads it back the very next cycle.
    next_cycle();
    drv_b(1'b1, 1'b1, 1'b0, 4'd3, 8'h18);
    settle();
    check("wr b_gnt", 8'(b_gnt), 8'h1);
    check("wr a_gnt", 8'(a_gnt), 8'h0);
    next_cycle();
    drv_b(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    drv_a(1'b1, 1'b0, 1'b0, 4'd3, 8'h00);
    settle();
    check("rd a_gnt", 8'(a_gnt), 8'h1);
    check("wr b_rvalid", 8'(b_rvalid), 8'h0);
    next_cycle();
    drv_a(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    settle();
    check("rd a_rvalid", 8'(a_rvalid), 8'h1);
    check("rd a_rdata", a_rdata, 8'h18);
    check("rd b_rvalid", 8'(b_rvalid), 8'h0);
    next_cycle(); settle();
    check("rd a_rvalid low", 8'(a_rvalid), 8'h0);
    check("rd a_rdata hold", a_rdata, 8'h18);

    // Locked read-complement-write on addr 5 while B waits for addr 5.
    next_cycle();
    drv_b(1'b1, 1'b1, 1'b0, 4'd5, 8'h5A);
    settle();
    check("rmw pre b_gnt", 8'(b_gnt), 8'h1);
    next_cycle();
    drv_a(1'b1, 1'b0, 1'b1, 4'd5, 8'h00);
    drv_b(1'b1, 1'b0, 1'b0, 4'd5, 8'h00);
    settle();
    check("rmw rd a_gnt", 8'(a_gnt), 8'h1);
    check("rmw rd b_gnt", 8'(b_gnt), 8'h0);
    next_cycle();
    drv_a(1'b0, 1'b0, 1'b0, 4'd5, 8'h00);
    settle();
    check("rmw blk b_gnt", 8'(b_gnt), 8'h0);
    check("rmw a_rvalid", 8'(a_rvalid), 8'h1);
    check("rmw a_rdata", a_rdata, 8'h5A);
    next_cycle();
    drv_a(1'b1, 1'b1, 1'b0, 4'd5, 8'hA5);
    settle();
    check("rmw wr a_gnt", 8'(a_gnt), 8'h1);
    check("rmw wr b_gnt", 8'(b_gnt), 8'h0);
    next_cycle();
    drv_a(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    settle();
    check("rmw rel b_gnt", 8'(b_gnt), 8'h1);
    check("rmw lock_err", 8'(lock_err), 8'h0);
    next_cycle();
    drv_b(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    settle();
    check("rmw b_rvalid", 8'(b_rvalid), 8'h1);
    check("rmw b_rdata", b_rdata, 8'hA5);

    // Lock timeout: A locks then goes quiet while B requests.
    next_cycle();
    drv_a(1'b1, 1'b0, 1'b1, 4'd3, 8'h00);
    settle();
    check("to a_gnt", 8'(a_gnt), 8'h1);
    next_cycle();
    drv_a(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    drv_b(1'b1, 1'b0, 1'b0, 4'd3, 8'h00);
    for (int k = 1; k <= 5; k++) begin
      settle();
      check("to lock_err", 8'(lock_err), 8'(k == 5));
      check("to b_gnt", 8'(b_gnt), 8'(k == 5));
      next_cycle();
    end
    drv_b(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    settle();
    check("to lock_err once", 8'(lock_err), 8'h0);
    check("to b_rvalid", 8'(b_rvalid), 8'h1);
    check("to b_rdata", b_rdata, 8'h18);

    // Owner access on the timeout cycle keeps the lock and suppresses lock_err.
    next_cycle();
    drv_a(1'b1, 1'b0, 1'b1, 4'd3, 8'h00);
    settle();
    check("race a_gnt", 8'(a_gnt), 8'h1);
    next_cycle();
    drv_a(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    drv_b(1'b1, 1'b0, 1'b0, 4'd5, 8'h00);
    for (int k = 1; k <= 3; k++) begin
      settle();
      check("race wait b_gnt", 8'(b_gnt), 8'h0);
      next_cycle();
    end
    drv_a(1'b1, 1'b0, 1'b1, 4'd3, 8'h00);
    settle();
    check("race owner a_gnt", 8'(a_gnt), 8'h1);
    next_cycle();
    drv_a(1'b1, 1'b0, 1'b0, 4'd3, 8'h00);
    settle();
    check("race lock_err", 8'(lock_err), 8'h0);
    check("race still locked b_gnt", 8'(b_gnt), 8'h0);
    check("race unlock a_gnt", 8'(a_gnt), 8'h1);
    next_cycle();
    drv_a(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    settle();
    check("race after b_gnt", 8'(b_gnt), 8'h1);
    check("race after lock_err", 8'(lock_err), 8'h0);

    // Reset while B holds the lock: back to IDLE with A favoured.
    next_cycle();
    drv_b(1'b1, 1'b0, 1'b1, 4'd3, 8'h00);
    settle();
    check("rl b_gnt", 8'(b_gnt), 8'h1);
    next_cycle();
    rst_n = 1'b0;
    drv_a(1'b1, 1'b0, 1'b0, 4'd3, 8'h00);
    drv_b(1'b1, 1'b0, 1'b0, 4'd5, 8'h00);
    settle();
    check("rl rst a_gnt", 8'(a_gnt), 8'h0);
    check("rl rst b_gnt", 8'(b_gnt), 8'h0);
    next_cycle();
    rst_n = 1'b1;
    settle();
    check("rl a_gnt", 8'(a_gnt), 8'h1);
    check("rl b_gnt", 8'(b_gnt), 8'h0);
    check("rl b_rvalid", 8'(b_rvalid), 8'h0);
    check("rl a_rdata", a_rdata, 8'h00);
    check("rl lock_err", 8'(lock_err), 8'h0);
    next_cycle(); settle();
    check("rl next b_gnt", 8'(b_gnt), 8'h1);
    check("rl next a_rvalid", 8'(a_rvalid), 8'h1);
    check("rl mem kept", a_rdata, 8'h18);
    next_cycle();
    drv_a(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    drv_b(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    for (int k = 0; k < 5; k++) begin
      settle();
      check("rl quiet lock_err", 8'(lock_err), 8'h0);
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
